// File: rtl/hash_collector.sv
// hash_collector: assembles one digest from the hash byte bus into a local buffer,
// exposes it through a registered read port, and keeps a running XOR checksum,
// a completed-digest counter and sticky protocol-error flags.
module hash_collector #(
  parameter int unsigned PMOD_W     = 8,
  parameter int unsigned HASH_BYTES = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PMOD_W-1:0] hash_i,
  input  logic              hash_valid_i,
  input  logic              hash_start_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PMOD_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [PMOD_W-1:0] checksum_o,
  output logic [CNT_W-1:0]  digest_cnt_o,
  output logic              stray_err_o,
  output logic              restart_err_o,
  output logic              timeout_err_o
);

  localparam int unsigned GapW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(HASH_BYTES - 1);
  localparam logic [ADDR_W:0]   NumBytes = (ADDR_W + 1)'(HASH_BYTES);
  localparam logic [GapW-1:0]   LastGap  = GapW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [PMOD_W-1:0] csum_q, csum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stray_q, stray_d;
  logic              restart_q, restart_d;
  logic              timeout_q, timeout_d;
  logic [PMOD_W-1:0] rd_data_q, rd_data_d;

  logic [PMOD_W-1:0] mem_q [HASH_BYTES];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              stray_ev, restart_ev, timeout_ev, complete_ev;

  // Capture FSM: decides buffer writes, index/gap/checksum updates and error events.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    csum_d      = csum_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    stray_ev    = 1'b0;
    restart_ev  = 1'b0;
    timeout_ev  = 1'b0;
    complete_ev = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (hash_valid_i) begin
          if (hash_start_i) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            idx_d   = ADDR_W'(1);
            gap_d   = '0;
            csum_d  = hash_i;
            state_d = StCapture;
          end else begin
            // Byte outside a capture is dropped; a frozen digest stays intact.
            stray_ev = 1'b1;
          end
        end
      end
      StCapture: begin
        if (hash_valid_i) begin
          gap_d = '0;
          wr_en = 1'b1;
          if (hash_start_i) begin
            restart_ev = 1'b1;
            wr_addr    = '0;
            idx_d      = ADDR_W'(1);
            csum_d     = hash_i;
          end else begin
            wr_addr = idx_q;
            csum_d  = csum_q ^ hash_i;
            if (idx_q == LastIdx) begin
              complete_ev = 1'b1;
              idx_d       = '0;
              state_d     = StDone;
            end else begin
              idx_d = idx_q + ADDR_W'(1);
            end
          end
        end else if (gap_q == LastGap) begin
          timeout_ev = 1'b1;
          gap_d      = '0;
          idx_d      = '0;
          state_d    = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags and digest counter; a coincident event beats clear_i.
  always_comb begin
    stray_d   = stray_ev   | (stray_q   & ~clear_i);
    restart_d = restart_ev | (restart_q & ~clear_i);
    timeout_d = timeout_ev | (timeout_q & ~clear_i);
    cnt_d     = clear_i ? '0 : cnt_q;
    if (complete_ev) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // Read mux: out-of-range addresses return zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_addr_i} < NumBytes) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      gap_q     <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
      stray_q   <= 1'b0;
      restart_q <= 1'b0;
      timeout_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      stray_q   <= stray_d;
      restart_q <= restart_d;
      timeout_q <= timeout_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Digest buffer; contents need no reset, a same-cycle read sees the old byte.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= hash_i;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign busy_o        = (state_q == StCapture);
  assign done_o        = (state_q == StDone);
  assign checksum_o    = csum_q;
  assign digest_cnt_o  = cnt_q;
  assign stray_err_o   = stray_q;
  assign restart_err_o = restart_q;
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_hash_collector.sv
// Directed bench for hash_collector: nominal, gapped, restart, timeout,
// stray/clear interaction, back-to-back digests and mid-capture reset.
module tb_hash_collector;

  localparam int unsigned PmodW     = 8;
  localparam int unsigned HashBytes = 32;
  localparam int unsigned AddrW     = 5;
  localparam int unsigned Timeout   = 1024;
  localparam int unsigned CntW      = 8;

  logic             clk;
  logic             rst_n;
  logic [PmodW-1:0] hash_i;
  logic             hash_valid_i;
  logic             hash_start_i;
  logic             clear_i;
  logic [AddrW-1:0] rd_addr_i;
  logic [PmodW-1:0] rd_data_o;
  logic             busy_o;
  logic             done_o;
  logic [PmodW-1:0] checksum_o;
  logic [CntW-1:0]  digest_cnt_o;
  logic             stray_err_o;
  logic             restart_err_o;
  logic             timeout_err_o;

  int n_checks = 0;
  int n_errors = 0;
  bit busy_dropped;

  hash_collector #(
    .PMOD_W    (PmodW),
    .HASH_BYTES(HashBytes),
    .ADDR_W    (AddrW),
    .TIMEOUT   (Timeout),
    .CNT_W     (CntW)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hash_i       (hash_i),
    .hash_valid_i (hash_valid_i),
    .hash_start_i (hash_start_i),
    .clear_i      (clear_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .checksum_o   (checksum_o),
    .digest_cnt_o (digest_cnt_o),
    .stray_err_o  (stray_err_o),
    .restart_err_o(restart_err_o),
    .timeout_err_o(timeout_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of bus inputs, then sample 1 time unit after the edge.
  task automatic cycle(input logic v, input logic s, input logic [7:0] d);
    hash_valid_i = v;
    hash_start_i = s;
    hash_i       = d;
    @(posedge clk);
    #1;
    hash_valid_i = 1'b0;
    hash_start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
  endtask

  // n bytes of base + step*i, optional start on the first, gap idle cycles between.
  task automatic send(input int n, input logic [7:0] base, input logic [7:0] step,
                      input bit start_first, input int gap);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + step * 8'(i);
      cycle(1'b1, start_first && (i == 0), d);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          cycle(1'b0, 1'b0, 8'h00);
          if (!busy_o) busy_dropped = 1'b1;
        end
      end
    end
  endtask

  task automatic read_chk(input string tag, input logic [AddrW-1:0] a, input logic [7:0] exp);
    rd_addr_i = a;
    idle(1);
    check(tag, 32'(rd_data_o), 32'(exp));
  endtask

  task automatic check_flags(input string tag, input bit s, input bit r, input bit t);
    check({tag, "_stray"},   32'(stray_err_o),   32'(s));
    check({tag, "_restart"}, 32'(restart_err_o), 32'(r));
    check({tag, "_timeout"}, 32'(timeout_err_o), 32'(t));
  endtask

  initial begin
    rst_n        = 1'b0;
    hash_i       = '0;
    hash_valid_i = 1'b0;
    hash_start_i = 1'b0;
    clear_i      = 1'b0;
    rd_addr_i    = '0;
    busy_dropped = 1'b0;

    #12;
    check("rst_rd_data", 32'(rd_data_o), 0);
    check("rst_busy",    32'(busy_o), 0);
    check("rst_done",    32'(done_o), 0);
    check("rst_csum",    32'(checksum_o), 0);
    check("rst_cnt",     32'(digest_cnt_o), 0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Nominal back-to-back digest 0x00..0x1F.
    send(31, 8'h00, 8'h01, 1'b1, 0);
    check("nom_busy_pre", 32'(busy_o), 1);
    check("nom_done_pre", 32'(done_o), 0);
    cycle(1'b1, 1'b0, 8'h1F);
    check("nom_done", 32'(done_o), 1);
    check("nom_busy", 32'(busy_o), 0);
    check("nom_cnt",  32'(digest_cnt_o), 1);
    check("nom_csum", 32'(checksum_o), 8'h00);
    read_chk("nom_rd5",  5'h05, 8'h05);
    read_chk("nom_rd31", 5'h1F, 8'h1F);

    // Stray byte while DONE: flagged, buffer untouched, digest still shown.
    cycle(1'b1, 1'b0, 8'hEE);
    check("stray_done_flag", 32'(stray_err_o), 1);
    check("stray_done_done", 32'(done_o), 1);
    read_chk("stray_done_rd0", 5'h00, 8'h00);
    read_chk("stray_done_rd1", 5'h01, 8'h01);

    // clear_i wipes flags and counter only.
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    check_flags("clr", 1'b0, 1'b0, 1'b0);
    check("clr_cnt",  32'(digest_cnt_o), 0);
    check("clr_done", 32'(done_o), 1);

    // Gapped stream, 3 idle cycles between bytes.
    send(HashBytes, 8'h00, 8'h01, 1'b1, 3);
    check("gap_busy_held", 32'(busy_dropped), 0);
    check("gap_done", 32'(done_o), 1);
    check("gap_cnt",  32'(digest_cnt_o), 1);
    check("gap_csum", 32'(checksum_o), 8'h00);
    check_flags("gap", 1'b0, 1'b0, 1'b0);
    read_chk("gap_rd5", 5'h05, 8'h05);

    // Restart: 10 bytes 0x50.., then start 0xAA + 31 x 0x01.
    send(10, 8'h50, 8'h01, 1'b1, 0);
    check("rst10_busy", 32'(busy_o), 1);
    cycle(1'b1, 1'b1, 8'hAA);
    check("restart_flag", 32'(restart_err_o), 1);
    send(31, 8'h01, 8'h00, 1'b0, 0);
    check("restart_done", 32'(done_o), 1);
    check("restart_cnt",  32'(digest_cnt_o), 2);
    check("restart_csum", 32'(checksum_o), 8'hAB);
    read_chk("restart_rd0", 5'h00, 8'hAA);
    read_chk("restart_rd9", 5'h09, 8'h01);

    // Timeout: start + 4 bytes, then a long gap.
    send(5, 8'h40, 8'h01, 1'b1, 0);
    check("to_done_cleared", 32'(done_o), 0);
    idle(Timeout - 2);
    check("to_busy_before", 32'(busy_o), 1);
    check("to_flag_before", 32'(timeout_err_o), 0);
    idle(2);
    check("to_flag", 32'(timeout_err_o), 1);
    check("to_busy", 32'(busy_o), 0);
    check("to_done", 32'(done_o), 0);
    check("to_cnt",  32'(digest_cnt_o), 2);

    // Clear coinciding with a stray byte in IDLE: the new error survives.
    clear_i = 1'b1;
    cycle(1'b1, 1'b0, 8'h77);
    clear_i = 1'b0;
    check_flags("clr_err", 1'b1, 1'b0, 1'b0);
    check("clr_err_cnt", 32'(digest_cnt_o), 0);

    // Two full digests; clear coincides with completion of the first.
    send(31, 8'h20, 8'h01, 1'b1, 0);
    clear_i = 1'b1;
    cycle(1'b1, 1'b0, 8'h3F);
    clear_i = 1'b0;
    check("two_a_cnt",   32'(digest_cnt_o), 1);
    check("two_a_stray", 32'(stray_err_o), 0);
    check("two_a_done",  32'(done_o), 1);
    send(HashBytes, 8'h80, 8'h01, 1'b1, 0);
    check("two_b_cnt", 32'(digest_cnt_o), 2);
    read_chk("two_b_rd3",  5'h03, 8'h83);
    read_chk("two_b_rd31", 5'h1F, 8'h9F);

    // Asynchronous reset in the middle of a capture.
    send(17, 8'h00, 8'h01, 1'b1, 0);
    check("mid_busy", 32'(busy_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_csum", 32'(checksum_o), 0);
    check("mid_rst_cnt",  32'(digest_cnt_o), 0);
    check("mid_rst_rd",   32'(rd_data_o), 0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send(HashBytes, 8'h00, 8'h01, 1'b1, 0);
    check("post_done", 32'(done_o), 1);
    check("post_cnt",  32'(digest_cnt_o), 1);
    check("post_csum", 32'(checksum_o), 8'h00);
    check_flags("post", 1'b0, 1'b0, 1'b0);
    read_chk("post_rd17", 5'h11, 8'h11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global guard so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
